// File: rtl/seven_seg_scan_ctrl.sv
// Count-tick prescaler, BCD carry chain and multiplexed common-anode scan for a 4-digit counter.
// Optional feature macro: LZ_BLANK_EN (leading-zero suppression); default build drives all digits.
module seven_seg_scan_ctrl #(
  parameter int TICK_DIV  = 12000000,
  parameter int SCAN_DIV  = 12000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [15:0] digit_q,
  output logic [3:0]  cnt_en,
  output logic        rollover,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int SW   = $clog2(SMAX);

  typedef enum logic {ST_BLANK, ST_SCAN} state_t;

  logic [TW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          hb_q, hb_d;
  logic          rollover_q, rollover_d;
  state_t        state_q, state_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [3:0]    nine;
  logic [3:0]    cur_digit;
  logic          lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;  // invalid BCD shown as a dash
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nine
      assign nine[gi] = (digit_q[4*gi +: 4] == 4'd9);
    end
  endgenerate

  // Carry ripples only through digits holding exactly 9.
  always_comb begin
    logic carry;
    cnt_en = 4'b0000;
    carry  = tick_q;
    for (int i = 0; i < 4; i++) begin
      cnt_en[i] = carry;
      carry     = carry & nine[i];
    end
  end

  always_comb begin
    presc_d    = presc_q;
    tick_d     = 1'b0;
    if (run) begin
      if (presc_q == TW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    hb_d       = hb_q ^ tick_q;
    rollover_d = tick_q & (&nine);
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q + 1'b1;
    idx_d   = idx_q;
    case (state_q)
      ST_BLANK: begin
        if (sc_q == SW'(BLANK_CYC - 1)) begin
          state_d = ST_SCAN;
          sc_d    = '0;
        end
      end
      default: begin
        if (sc_q == SW'(SCAN_DIV - 1)) begin
          state_d = ST_BLANK;
          sc_d    = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
    endcase
  end

  assign cur_digit = digit_q[{idx_q, 2'b00} +: 4];

`ifdef LZ_BLANK_EN
  assign lz_blank = (idx_q != 2'd0) && ((digit_q >> {idx_q, 2'b00}) == 16'h0000);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_q == ST_SCAN && !lz_blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(cur_digit);
      dp_d  = ~((idx_q == 2'd0) & hb_q);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      hb_q       <= 1'b0;
      rollover_q <= 1'b0;
      state_q    <= ST_BLANK;
      sc_q       <= '0;
      idx_q      <= 2'd0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      hb_q       <= hb_d;
      rollover_q <= rollover_d;
      state_q    <= state_d;
      sc_q       <= sc_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign rollover = rollover_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl against a cycle-count based reference model.
module tb_seven_seg_scan_ctrl;
  localparam int TICK_DIV  = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int PERIOD    = SCAN_DIV + BLANK_CYC;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic [15:0] digit_q = 16'h0000;
  logic [3:0]  cnt_en;
  logic        rollover;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tbl [16];

  // reference model state
  int m_run_cnt;   // run-high edges since reset
  bit m_tick;
  int m_ticks;     // ticks seen since reset
  int m_cyc;       // edges since reset

  seven_seg_scan_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clock(clock), .clear(clear), .run(run), .digit_q(digit_q),
    .cnt_en(cnt_en), .rollover(rollover), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_cnt_en(input bit tick, input logic [15:0] dq);
    logic [3:0] e;
    int n;
    e = 4'b0000;
    if (tick) begin
      n = 1;
      for (int i = 0; i < 3; i++) begin
        if (dq[4*i +: 4] == 4'd9 && n == i + 1) n++;
      end
      e = 4'((1 << n) - 1);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_run_cnt = 0;
    m_tick = 0;
    m_ticks = 0;
    m_cyc = 0;
  endtask

  // One clock: starts at a negedge, applies inputs, checks just after the posedge, returns at the next negedge.
  task automatic step(input logic r, input logic [15:0] dq);
    bit         old_tick;
    bit         hb_before;
    int         pos, idx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_roll;
    run = r;
    digit_q = dq;
    @(posedge clock);
    #1;
    old_tick  = m_tick;
    hb_before = (m_ticks - (old_tick ? 1 : 0)) % 2 == 1;
    e_roll = old_tick && (dq == 16'h9999);
    pos = m_cyc % PERIOD;
    idx = (m_cyc / PERIOD) % 4;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (pos >= BLANK_CYC) begin
      e_an  = 4'hF ^ 4'(1 << idx);
      e_seg = seg_tbl[dq[4*idx +: 4]];
      e_dp  = !(idx == 0 && hb_before);
`ifdef LZ_BLANK_EN
      if (idx > 0 && (dq >> (4*idx)) == 0) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
`endif
    end
    if (r) m_run_cnt++;
    m_tick = r && (m_run_cnt % TICK_DIV == 0);
    if (m_tick) m_ticks++;
    m_cyc++;
    check_eq("an", 16'(an), 16'(e_an));
    check_eq("seg", 16'(seg), 16'(e_seg));
    check_eq("dp", 16'(dp), 16'(e_dp));
    check_eq("rollover", 16'(rollover), 16'(e_roll));
    check_eq("cnt_en", 16'(cnt_en), 16'(exp_cnt_en(m_tick, dq)));
    $display("cyc=%0d run=%0b dq=%h an=%h seg=%h dp=%0b cnt_en=%b roll=%0b",
             m_cyc, r, dq, an, seg, dp, cnt_en, rollover);
    @(negedge clock);
  endtask

  function automatic logic [15:0] rand_dq();
    logic [15:0] v;
    int r;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       v[4*i +: 4] = 4'd9;
      else if (r < 9)  v[4*i +: 4] = 4'd0;
      else if (r < 14) v[4*i +: 4] = 4'($urandom_range(0, 9));
      else             v[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  initial begin
    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    model_reset();
    clear = 1'b1;
    @(posedge clock);
    #1;
    check_eq("rst_an", 16'(an), 16'hF);
    check_eq("rst_seg", 16'(seg), 16'h7F);
    check_eq("rst_dp", 16'(dp), 16'h1);
    check_eq("rst_cnt_en", 16'(cnt_en), 16'h0);
    check_eq("rst_rollover", 16'(rollover), 16'h0);
    @(negedge clock);
    clear = 1'b0;

    for (int i = 0; i < 45; i++) step(1'b1, 16'h0000);   // scan order E,D,B,7,E
    for (int i = 0; i < 12; i++) step(1'b1, 16'h0009);
    for (int i = 0; i < 12; i++) step(1'b1, 16'h9999);
    for (int i = 0; i < 12; i++) step(1'b1, 16'h9899);
    for (int i = 0; i < 44; i++) step(1'b1, 16'h000C);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h9999);
    for (int i = 0; i < 44; i++) step(1'b1, 16'h0050);
    for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 3) != 0), rand_dq());

    // Clear in the middle of the slot-2 scan window.
    for (int i = 0; i < 200; i++) begin
      if (((m_cyc - 1) / PERIOD) % 4 == 2 && ((m_cyc - 1) % PERIOD) >= BLANK_CYC + 3) break;
      step(1'b1, 16'h9999);
    end
    check_eq("slot2_reached", 16'(an), 16'hB);
    #2;
    clear = 1'b1;
    #1;
    check_eq("clr_an", 16'(an), 16'hF);
    check_eq("clr_seg", 16'(seg), 16'h7F);
    check_eq("clr_dp", 16'(dp), 16'h1);
    check_eq("clr_cnt_en", 16'(cnt_en), 16'h0);
    check_eq("clr_rollover", 16'(rollover), 16'h0);
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    model_reset();
    for (int i = 0; i < 45; i++) step(1'b1, 16'h1234);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), rand_dq());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
